// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit: ALU operand select codes,
// stall FSM encoding and the hard-wired zero register.
package forwarding_pkg;

    localparam logic [1:0] SEL_REG_FILE = 2'b00;
    localparam logic [1:0] SEL_MEM_WB   = 2'b01;
    localparam logic [1:0] SEL_EX_MEM   = 2'b10;

    localparam int unsigned REG_ZERO = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage : forwarding_pkg

// File: rtl/forwarding_hazard_unit_if.sv
// Pipeline-side bundle of the forwarding/hazard unit. With FORWARDING_HAZARD_BRANCH_ID_EN
// defined the bundle also carries i_branch_id for ID-stage branch comparisons.
interface forwarding_hazard_unit_if #(
    parameter int CANT_BITS_ADDR_REGISTROS = 5,
    parameter int CANT_BITS_SELECTOR_MUX   = 2,
    parameter int CANT_OPERANDOS           = 2,
    parameter int CANT_BITS_CONTADOR       = 16
) ();

    logic [CANT_OPERANDOS*CANT_BITS_ADDR_REGISTROS-1:0] i_rs_addr;
    logic [CANT_OPERANDOS-1:0]                          i_rs_used;
    logic [CANT_BITS_ADDR_REGISTROS-1:0]                i_id_ex_rd;
    logic [CANT_BITS_ADDR_REGISTROS-1:0]                i_ex_mem_rd;
    logic                                               i_id_ex_reg_write;
    logic                                               i_ex_mem_reg_write;
    logic                                               i_id_ex_mem_read;
`ifdef FORWARDING_HAZARD_BRANCH_ID_EN
    logic                                               i_branch_id;
`endif
    logic [CANT_OPERANDOS*CANT_BITS_SELECTOR_MUX-1:0]   o_selector_mux;
    logic                                               o_stall;
    logic                                               o_flush_id_ex;
    logic [CANT_BITS_CONTADOR-1:0]                      o_contador_stalls;

    // Pipeline control side: drives the ID/EX/MEM view, consumes selects and stalls.
    modport master (
`ifdef FORWARDING_HAZARD_BRANCH_ID_EN
        output i_branch_id,
`endif
        output i_rs_addr, i_rs_used, i_id_ex_rd, i_ex_mem_rd,
        output i_id_ex_reg_write, i_ex_mem_reg_write, i_id_ex_mem_read,
        input  o_selector_mux, o_stall, o_flush_id_ex, o_contador_stalls
    );

    // Forwarding/hazard unit side.
    modport slave (
`ifdef FORWARDING_HAZARD_BRANCH_ID_EN
        input  i_branch_id,
`endif
        input  i_rs_addr, i_rs_used, i_id_ex_rd, i_ex_mem_rd,
        input  i_id_ex_reg_write, i_ex_mem_reg_write, i_id_ex_mem_read,
        output o_selector_mux, o_stall, o_flush_id_ex, o_contador_stalls
    );

endinterface : forwarding_hazard_unit_if

// File: rtl/forwarding_hazard_unit_selector.sv
// Per-operand forwarding decision: picks the newest in-flight producer of one
// ID-stage source register and flags a load-use hit against the EX instruction.
module forwarding_selector
    import forwarding_pkg::*;
#(
    parameter int CANT_BITS_ADDR_REGISTROS = 5,
    parameter int CANT_BITS_SELECTOR_MUX   = 2
) (
    input  logic [CANT_BITS_ADDR_REGISTROS-1:0] rs_addr,
    input  logic                                rs_used,
    input  logic [CANT_BITS_ADDR_REGISTROS-1:0] id_ex_rd,
    input  logic [CANT_BITS_ADDR_REGISTROS-1:0] ex_mem_rd,
    input  logic                                id_ex_reg_write,
    input  logic                                ex_mem_reg_write,
    input  logic                                id_ex_mem_read,
    output logic [CANT_BITS_SELECTOR_MUX-1:0]   selector,
    output logic                                load_hit
);

    logic eligible_s;
    logic ex_hit_s;
    logic mem_hit_s;

    // Compare against EX and MEM producers; EX holds the newer value so it wins.
    always_comb begin
        eligible_s = rs_used && (rs_addr != CANT_BITS_ADDR_REGISTROS'(REG_ZERO));
        ex_hit_s   = eligible_s && id_ex_reg_write  && (rs_addr == id_ex_rd);
        mem_hit_s  = eligible_s && ex_mem_reg_write && (rs_addr == ex_mem_rd);
        load_hit   = eligible_s && id_ex_mem_read   && (rs_addr == id_ex_rd);
        if (ex_hit_s) begin
            selector = CANT_BITS_SELECTOR_MUX'(SEL_EX_MEM);
        end else if (mem_hit_s) begin
            selector = CANT_BITS_SELECTOR_MUX'(SEL_MEM_WB);
        end else begin
            selector = CANT_BITS_SELECTOR_MUX'(SEL_REG_FILE);
        end
    end

endmodule : forwarding_selector

// File: rtl/forwarding_hazard_unit.sv
// Forwarding select generation (decided in ID, registered into EX) plus load-use
// stall FSM and saturating stall counter. Optional: FORWARDING_HAZARD_BRANCH_ID_EN.
module forwarding_hazard_unit
    import forwarding_pkg::*;
#(
    parameter int CANT_BITS_ADDR_REGISTROS = 5,
    parameter int CANT_BITS_SELECTOR_MUX   = 2,
    parameter int CANT_OPERANDOS           = 2,
    parameter int LATENCIA_LOAD            = 1,
    parameter int CANT_BITS_CONTADOR       = 16
) (
    input  logic                   i_clock,
    input  logic                   i_soft_reset,
    input  logic                   i_enable,
    forwarding_hazard_unit_if.slave bus
);

    localparam int A     = CANT_BITS_ADDR_REGISTROS;
    localparam int S     = CANT_BITS_SELECTOR_MUX;
    localparam int CNT_W = $clog2(LATENCIA_LOAD + 2) + 1;

    logic [CANT_OPERANDOS*S-1:0]     sel_next_s;
    logic [CANT_OPERANDOS-1:0]       load_hit_s;
    logic [CNT_W-1:0]                need_s;
    logic                            hazard_s;
    logic                            stall_s;
    state_t                          state_r;
    logic [CNT_W-1:0]                cnt_r;
    logic [CANT_OPERANDOS*S-1:0]     sel_r;
    logic [CANT_BITS_CONTADOR-1:0]   stalls_r;

    for (genvar k = 0; k < CANT_OPERANDOS; k++) begin : g_op
        forwarding_selector #(
            .CANT_BITS_ADDR_REGISTROS (A),
            .CANT_BITS_SELECTOR_MUX   (S)
        ) u_selector (
            .rs_addr          (bus.i_rs_addr[k*A +: A]),
            .rs_used          (bus.i_rs_used[k]),
            .id_ex_rd         (bus.i_id_ex_rd),
            .ex_mem_rd        (bus.i_ex_mem_rd),
            .id_ex_reg_write  (bus.i_id_ex_reg_write),
            .ex_mem_reg_write (bus.i_ex_mem_reg_write),
            .id_ex_mem_read   (bus.i_id_ex_mem_read),
            .selector         (sel_next_s[k*S +: S]),
            .load_hit         (load_hit_s[k])
        );
    end

`ifdef FORWARDING_HAZARD_BRANCH_ID_EN
    logic             ex_any_s;
    logic             mem_any_s;
    logic [CNT_W-1:0] branch_need_s;

    // Branches compare in ID, so any in-flight producer forces a wait; a MEM
    // match only counts when the EX instruction is not already that operand's source.
    always_comb begin
        ex_any_s  = 1'b0;
        mem_any_s = 1'b0;
        for (int k = 0; k < CANT_OPERANDOS; k++) begin
            ex_any_s  = ex_any_s  | (sel_next_s[k*S +: S] == S'(SEL_EX_MEM));
            mem_any_s = mem_any_s | (sel_next_s[k*S +: S] == S'(SEL_MEM_WB));
        end
        if (!bus.i_branch_id) begin
            branch_need_s = '0;
        end else if (ex_any_s && bus.i_id_ex_mem_read) begin
            branch_need_s = CNT_W'(LATENCIA_LOAD + 1);
        end else if (ex_any_s || mem_any_s) begin
            branch_need_s = CNT_W'(1);
        end else begin
            branch_need_s = '0;
        end
    end
`endif

    // Stall cycles requested by the ID instruction; the larger requirement wins.
    always_comb begin
        if (|load_hit_s) begin
            need_s = CNT_W'(LATENCIA_LOAD);
        end else begin
            need_s = '0;
        end
`ifdef FORWARDING_HAZARD_BRANCH_ID_EN
        if (branch_need_s > need_s) begin
            need_s = branch_need_s;
        end else begin
            need_s = need_s;
        end
`endif
        hazard_s = (state_r == ST_IDLE) && (need_s != '0);
        stall_s  = (state_r == ST_STALL) || hazard_s;
    end

    // Stall FSM: the IDLE hazard cycle is the first stall cycle, STALL covers the rest.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else if (i_enable) begin
            case (state_r)
                ST_IDLE: begin
                    if (hazard_s && (need_s > CNT_W'(1))) begin
                        state_r <= ST_STALL;
                        cnt_r   <= need_s - CNT_W'(1);
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end
                end
                ST_STALL: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= ST_STALL;
                        cnt_r   <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // EX-stage selects (bubble loads zero) and saturating stall counter.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            sel_r    <= '0;
            stalls_r <= '0;
        end else if (i_enable) begin
            sel_r <= stall_s ? '0 : sel_next_s;
            if (stall_s && (stalls_r != {CANT_BITS_CONTADOR{1'b1}})) begin
                stalls_r <= stalls_r + CANT_BITS_CONTADOR'(1);
            end
        end
    end

    assign bus.o_selector_mux    = sel_r;
    assign bus.o_contador_stalls = stalls_r;
    assign bus.o_stall           = stall_s;
    assign bus.o_flush_id_ex     = stall_s;

endmodule : forwarding_hazard_unit

// File: tb/tb_forwarding_hazard_unit.sv
// Bench: single-cycle forwarding vectors on a LATENCIA_LOAD=1 unit, then
// multi-cycle stall/reset/enable/saturation sequences on a LATENCIA_LOAD=3 unit.
module tb_forwarding_hazard_unit;

    logic clk = 1'b0;
    logic rst;
    logic en;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    forwarding_hazard_unit_if #(.CANT_BITS_CONTADOR(16)) if1 ();
    forwarding_hazard_unit_if #(.CANT_BITS_CONTADOR(3))  if3 ();

    forwarding_hazard_unit #(.LATENCIA_LOAD(1), .CANT_BITS_CONTADOR(16)) dut1 (
        .i_clock(clk), .i_soft_reset(rst), .i_enable(en), .bus(if1.slave));
    forwarding_hazard_unit #(.LATENCIA_LOAD(3), .CANT_BITS_CONTADOR(3)) dut3 (
        .i_clock(clk), .i_soft_reset(rst), .i_enable(en), .bus(if3.slave));

    typedef struct {
        string      name;
        logic [9:0] rs_addr;
        logic [1:0] rs_used;
        logic [4:0] id_ex_rd;
        logic [4:0] ex_mem_rd;
        logic       id_rw;
        logic       mem_rw;
        logic       mem_read;
        logic       exp_stall;
        logic [3:0] exp_sel;
    } vec_t;

    vec_t       vecs[12];
    logic [3:0] sel_q[$];

    function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs0, logic [1:0] used,
                                logic [4:0] idrd, logic [4:0] memrd, logic idrw, logic memrw,
                                logic mr, logic st, logic [3:0] sel);
        vec_t v;
        v.name = n; v.rs_addr = {rs1, rs0}; v.rs_used = used;
        v.id_ex_rd = idrd; v.ex_mem_rd = memrd; v.id_rw = idrw; v.mem_rw = memrw;
        v.mem_read = mr; v.exp_stall = st; v.exp_sel = sel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set3(input logic [4:0] rs0, input logic used0, input logic [4:0] idrd,
                        input logic [4:0] memrd, input logic idrw, input logic memrw,
                        input logic mr);
        if3.i_rs_addr = {5'd0, rs0}; if3.i_rs_used = {1'b0, used0};
        if3.i_id_ex_rd = idrd; if3.i_ex_mem_rd = memrd;
        if3.i_id_ex_reg_write = idrw; if3.i_ex_mem_reg_write = memrw;
        if3.i_id_ex_mem_read = mr;
    endtask

    // One cycle on dut3: check the combinational stall, queue the select, advance, compare.
    task automatic cyc3(input string name, input logic exp_stall, input logic [3:0] exp_sel);
        logic [3:0] e;
        #1;
        chk({name, "_stall"}, 32'(if3.o_stall), 32'(exp_stall));
        chk({name, "_flush"}, 32'(if3.o_flush_id_ex), 32'(exp_stall));
        sel_q.push_back(exp_sel);
        @(posedge clk); #1;
        if (sel_q.size() == 0) begin
            chk({name, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = sel_q.pop_front();
            chk({name, "_sel"}, 32'(if3.o_selector_mux), 32'(e));
        end
    endtask

    // Load-use hazard on rs0=r2 for one cycle, then two more cycles of idle inputs.
    task automatic load_stall3(input string name);
        set3(5'd2, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc3({name, "_c0"}, 1'b1, 4'b0000);
        set3(5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc3({name, "_c1"}, 1'b1, 4'b0000);
        cyc3({name, "_c2"}, 1'b1, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] e;
        int         exp_cnt;

        vecs[0]  = mk("fwd_ex_rs0",   5'd0, 5'd3, 2'b01, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010);
        vecs[1]  = mk("fwd_mem_rs1",  5'd4, 5'd0, 2'b10, 5'd7, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100);
        vecs[2]  = mk("ex_wins_rs1",  5'd4, 5'd0, 2'b10, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000);
        vecs[3]  = mk("reg_zero",     5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        vecs[4]  = mk("unused_rs0",   5'd0, 5'd5, 2'b00, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        vecs[5]  = mk("load_use",     5'd0, 5'd2, 2'b01, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
        vecs[6]  = mk("after_load",   5'd0, 5'd2, 2'b01, 5'd9, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
        vecs[7]  = mk("both_ops",     5'd7, 5'd6, 2'b11, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110);
        vecs[8]  = mk("same_reg",     5'd8, 5'd8, 2'b11, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010);
        vecs[9]  = mk("no_write",     5'd0, 5'd3, 2'b01, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        vecs[10] = mk("load_rs1",     5'd2, 5'd3, 2'b11, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
        vecs[11] = mk("load_unused",  5'd2, 5'd0, 2'b00, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);

        rst = 1'b1; en = 1'b1;
`ifdef FORWARDING_HAZARD_BRANCH_ID_EN
        if1.i_branch_id = 1'b0;
        if3.i_branch_id = 1'b0;
`endif
        if1.i_rs_addr = '0; if1.i_rs_used = '0; if1.i_id_ex_rd = '0; if1.i_ex_mem_rd = '0;
        if1.i_id_ex_reg_write = 1'b0; if1.i_ex_mem_reg_write = 1'b0; if1.i_id_ex_mem_read = 1'b0;
        set3(5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel1",   32'(if1.o_selector_mux),    32'd0);
        chk("rst_cnt1",   32'(if1.o_contador_stalls), 32'd0);
        chk("rst_stall1", 32'(if1.o_stall),           32'd0);
        chk("rst_sel3",   32'(if3.o_selector_mux),    32'd0);
        chk("rst_cnt3",   32'(if3.o_contador_stalls), 32'd0);
        rst = 1'b0;

        // Single-cycle vectors on the LATENCIA_LOAD=1 unit.
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if1.i_rs_addr = vecs[i].rs_addr; if1.i_rs_used = vecs[i].rs_used;
            if1.i_id_ex_rd = vecs[i].id_ex_rd; if1.i_ex_mem_rd = vecs[i].ex_mem_rd;
            if1.i_id_ex_reg_write = vecs[i].id_rw; if1.i_ex_mem_reg_write = vecs[i].mem_rw;
            if1.i_id_ex_mem_read = vecs[i].mem_read;
            #1;
            chk({vecs[i].name, "_stall"}, 32'(if1.o_stall),       32'(vecs[i].exp_stall));
            chk({vecs[i].name, "_flush"}, 32'(if1.o_flush_id_ex), 32'(vecs[i].exp_stall));
            sel_q.push_back(vecs[i].exp_sel);
            if (vecs[i].exp_stall) exp_cnt++;
            @(posedge clk); #1;
            if (sel_q.size() == 0) begin
                chk({vecs[i].name, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                e = sel_q.pop_front();
                chk({vecs[i].name, "_sel"}, 32'(if1.o_selector_mux), 32'(e));
            end
        end
        chk("cnt1_total", 32'(if1.o_contador_stalls), 32'(exp_cnt));

        // LATENCIA_LOAD=3: exactly three stall cycles, forwarding resumes after.
        set3(5'd2, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc3("l3_c0", 1'b1, 4'b0000);
        set3(5'd2, 1'b1, 5'd9, 5'd2, 1'b0, 1'b1, 1'b0);
        cyc3("l3_c1", 1'b1, 4'b0000);
        cyc3("l3_c2", 1'b1, 4'b0000);
        cyc3("l3_c3", 1'b0, 4'b0001);
        chk("l3_cnt", 32'(if3.o_contador_stalls), 32'd3);

        // Reset during the second cycle of a stall.
        set3(5'd2, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc3("rs_c0", 1'b1, 4'b0000);
        set3(5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc3("rs_c1", 1'b1, 4'b0000);
        rst = 1'b0;
        chk("rs_cnt", 32'(if3.o_contador_stalls), 32'd0);
        cyc3("rs_idle", 1'b0, 4'b0000);

        // Enable low mid-stall freezes state, counter and selects.
        set3(5'd2, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc3("en_c0", 1'b1, 4'b0000);
        set3(5'd2, 1'b1, 5'd9, 5'd2, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) cyc3("en_frozen", 1'b1, 4'b0000);
        chk("en_cnt_frozen", 32'(if3.o_contador_stalls), 32'd1);
        en = 1'b1;
        cyc3("en_c1", 1'b1, 4'b0000);
        cyc3("en_c2", 1'b1, 4'b0000);
        cyc3("en_c3", 1'b0, 4'b0001);
        chk("en_cnt", 32'(if3.o_contador_stalls), 32'd3);
        set3(5'd3, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        cyc3("en_sel_hold", 1'b0, 4'b0001);
        en = 1'b1;
        cyc3("en_sel_new", 1'b0, 4'b0010);

        // Counter saturation at all-ones (3-bit counter).
        load_stall3("sat_a");
        chk("sat_cnt6", 32'(if3.o_contador_stalls), 32'd6);
        load_stall3("sat_b");
        chk("sat_cnt7", 32'(if3.o_contador_stalls), 32'd7);
        cyc3("sat_idle", 1'b0, 4'b0000);
        chk("sat_hold", 32'(if3.o_contador_stalls), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_forwarding_hazard_unit

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Next-generation forwarding unit for the 5-stage MIPS pipeline, parametrised in operand count and load latency.
- Forwarding selects are computed one cycle early from ID-stage operands and registered into the EX stage alongside ID/EX.
- Adds load-use hazard detection with a stall FSM (PC/IF-ID freeze plus ID/EX bubble) and a saturating stall counter for the debug unit.

Parameters:
- CANT_BITS_ADDR_REGISTROS, 5, register address width.
- CANT_BITS_SELECTOR_MUX, 2, width of one operand's forwarding select.
- CANT_OPERANDOS, 2, source operands checked per instruction (rs, rt, ...).
- LATENCIA_LOAD, 1, stall cycles inserted per load-use hazard (>=1).
- CANT_BITS_CONTADOR, 16, stall counter width.

Ports:
- i_clock  in  1  system clock; all state updates on rising edge.
- i_soft_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  debug step enable; 0 holds all state.
- i_rs_addr  in  CANT_OPERANDOS*CANT_BITS_ADDR_REGISTROS  ID-stage source addresses; operand k at slice k.
- i_rs_used  in  CANT_OPERANDOS  per-operand "actually read" flag.
- i_id_ex_rd, i_ex_mem_rd  in  CANT_BITS_ADDR_REGISTROS each  destinations of instructions now in EX and MEM.
- i_id_ex_reg_write, i_ex_mem_reg_write, i_id_ex_mem_read  in  1 each  write enables; EX instruction is a load.
- o_selector_mux  out  CANT_OPERANDOS*CANT_BITS_SELECTOR_MUX  registered EX-stage ALU input selects.
- o_stall  out  1  freeze PC and IF/ID.
- o_flush_id_ex  out  1  load bubble into ID/EX.
- o_contador_stalls  out  CANT_BITS_CONTADOR  cumulative stall cycles.

Behaviour:
- Select codes: 00 register file, 01 MEM/WB, 10 EX/MEM, 11 unused (never driven).
- Per operand k, next select is decided combinationally in ID:
  - Operand k is eligible only if used[k]=1 and rs[k]!=0.
  - 10 if eligible, id_ex_reg_write, rs[k]==id_ex_rd.
  - Else 01 if eligible, ex_mem_reg_write, rs[k]==ex_mem_rd.
  - Else 00.
  - EX/MEM wins when both match (newest value).
- Load-use hazard: in IDLE, i_id_ex_mem_read and id_ex_rd!=0 and any eligible rs[k]==id_ex_rd.
- FSM states IDLE, STALL; down-counter cnt.
  - IDLE + hazard: o_stall=o_flush_id_ex=1 this same cycle (combinational).
  - If LATENCIA_LOAD>1, go to STALL with cnt=LATENCIA_LOAD-1; otherwise remain IDLE.
  - STALL: o_stall=o_flush_id_ex=1; hazard check suppressed; cnt decrements.
  - STALL exits to IDLE on the edge where cnt==1.
  - Total stall = exactly LATENCIA_LOAD cycles.
  - In the first IDLE cycle after a stall, selects and hazards are re-evaluated normally.
- o_selector_mux register, on an enabled edge:
  - Loads 0 when o_stall=1 (bubble);
  - otherwise loads the computed selects.
  - Latency: 1 cycle, ID decision to EX output.
- The register file is write-before-read, so no WB-stage forward is needed.
- o_contador_stalls: +1 per enabled edge with o_stall=1; saturates at all-ones.
- i_enable=0: FSM, cnt, selectors and counter hold; o_stall/o_flush_id_ex still reflect current state/hazard.
- Reset (wins over enable, including mid-stall): state IDLE, cnt 0, o_selector_mux 0, o_contador_stalls 0, hence o_stall=o_flush_id_ex=0 unless an IDLE hazard is present at the inputs.

Optional Feature:
- Macro: FORWARDING_HAZARD_BRANCH_ID_EN.
- Defined:
  - Adds input i_branch_id (1 bit), asserted when the ID instruction is a branch that compares operands in ID.
  - Branch operand matching id_ex_rd with id_ex_reg_write: stall 1 cycle if non-load, LATENCIA_LOAD+1 cycles if load.
  - Branch operand matching ex_mem_rd with i_ex_mem_reg_write while the MEM instruction is not handled above: stall 1 cycle.
  - Same FSM and counter are used, loaded with the larger requirement.
- Undefined: port absent; branches are treated as ordinary instructions.

Decomposition:
- Package forwarding_pkg holds:
  - Select codes SEL_REG_FILE/SEL_MEM_WB/SEL_EX_MEM.
  - FSM state encoding.
  - Register-zero constant.
- One sub-module, forwarding_selector: combinational per-operand compare/priority.
  - Instantiated CANT_OPERANDOS times via generate.
  - Outputs the select plus a load-hit flag.

Test Plan:
- rs0=3 used, id_ex_rd=3 reg_write, no load -> next cycle select0=10, no stall.
- rs1=4, ex_mem_rd=4 write, id_ex_rd=7 -> select1=01; with id_ex_rd=4 also writing -> select1=10.
- rs0=0, id_ex_rd=0 writing; also rs0=5 with used0=0 -> select 00, no stall.
- Load id_ex_rd=2, rs0=2 used:
  - LATENCIA_LOAD=1 -> o_stall=1 one cycle, selects 00; then ex_mem_rd=2 gives select0=01; counter=1.
  - LATENCIA_LOAD=3 -> exactly 3 stall cycles.
- Reset asserted during 2nd cycle of a 3-cycle stall -> next edge: IDLE, counter 0, selects 0.
- Counter at all-ones plus another stall -> stays all-ones; i_enable=0 during stall -> state frozen, stall held.
